mpmc11_req_arb: RTL
===================

# mpmc11_req_arb

Multi-port request arbiter for the mpmc11 memory controller. Sits directly upstream of the controller state machine. Buffers command requests from up to 16 client ports in per-port FIFOs. Selects one request per cycle round-robin and presents it, tagged with its source port number, as an `mpmc11_fifoe_t` entry on a valid/ready handshake.

## Interface

Parameters:
- `NPORT`, 8: number of client ports; legal range 1..16, limited by the 4-bit `port` field.
- `DEPTH`, 4: entries per port FIFO; power of two, at least 2.

Ports (clock and reset first):
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `req_vld_i`  input  NPORT: request valid, one bit per port.
- `req_rdy_o`  output  NPORT: port FIFO can accept this cycle.
- `req_i`  input  NPORT x `fta_bus_pkg::fta_cmd_request256_t`: request payload per port; carried opaquely, never decoded.
- `fifoe_o`  output  `mpmc11_pkg::mpmc11_fifoe_t`: selected request plus 4-bit source port.
- `fifoe_vld_o`  output  1: `fifoe_o` holds a valid entry.
- `fifoe_rdy_i`  input  1: downstream controller accepts the entry this cycle.
- `occ_o`  output  NPORT x $clog2(DEPTH+1): per-port FIFO occupancy.

## Operation

- **Input side.** A port FIFO write occurs when `req_vld_i[p] && req_rdy_o[p]`.
  - `req_rdy_o[p] = !rst && occ[p] != DEPTH`.
  - A full FIFO refuses the write even if it is popped in the same cycle (no pass-through).
- **FIFO structure.** Each FIFO uses read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
  - Simultaneous push and pop leaves occupancy unchanged.
- **Output register.** The output register loads when `load = !fifoe_vld_o || fifoe_rdy_i`.
- **Arbiter.** Combinational.
  - Candidate set: all ports with `occ[p] != 0`.
  - Search starts at `last+1` (mod NPORT), where `last` is the last granted port; the first candidate found wins.
  - On `load` with a candidate: pop the winner's FIFO head, write `{port=winner, req=head}` into the output register, set `fifoe_vld_o=1`, and set `last=winner`.
  - On `load` with no candidate: `fifoe_vld_o` goes to 0 and `last` is unchanged.
- **Hold rule.** While `fifoe_vld_o && !fifoe_rdy_i`, `fifoe_o` and `fifoe_vld_o` are held bit-stable, no FIFO is popped, and `last` is held.
- **Per-port ordering.** Requests from one port leave in arrival order. Across ports the order is round-robin only; no ordering is guaranteed between ports.
- **Fairness.** With all ports continuously non-empty and `fifoe_rdy_i=1`, each port is granted exactly once in every NPORT consecutive grants.
- **Port field width.** The `port` field is zero-extended to 4 bits.
- **Reset behaviour.** `rst` clears all FIFO pointers and occupancies, `fifoe_vld_o=0`, and `last=NPORT-1`, so port 0 has first priority.
  - Buffered contents are discarded.
  - `fifoe_o` payload resets to 0.
  - `req_rdy_o=0` while `rst` is high; it becomes all-ones in the first cycle after `rst` deasserts.
  - Reset asserted mid-handshake drops the pending entry; the controller must not see it after reset.

## Timing

- **Latency.** A request accepted at edge t is written into the FIFO. It is visible to the arbiter in cycle t+1 and, if it wins and `load` is true, is registered at edge t+1. `fifoe_vld_o` is therefore first high in the cycle after edge t+1: two edges from request acceptance to output valid.
- **Throughput.** With `fifoe_rdy_i` held high and any FIFO non-empty, one entry is issued per cycle.
- **Back-pressure.**
  - `req_rdy_o[p]` depends only on registered occupancy and `rst`, with no combinational path from `fifoe_rdy_i`.
  - `fifoe_vld_o` depends only on registered state.
- **Pointer wrap.** A FIFO holds DEPTH back-to-back writes. The (DEPTH+1)-th write is refused until a pop.

## Test plan

- **Reset values.** Assert `rst` for 2 cycles with `req_vld_i` all-ones -> `req_rdy_o=0` and `fifoe_vld_o=0` during reset. In the first cycle after reset: `req_rdy_o=8'hFF`, all `occ_o=0`, no entry issued.
- **Single request latency.** Port 5 writes one request with tag 0xA5 at edge t and `fifoe_rdy_i=1` -> `fifoe_vld_o=1` in the cycle after edge t+1, with `fifoe_o.port=5` and payload equal to the input. `fifoe_vld_o=0` in the following cycle.
- **Round-robin fairness.** Load 2 requests into each of ports 0..7, then raise `fifoe_rdy_i` -> grant order is 0,1,…,7,0,1,…,7, and 16 entries are issued in 16 consecutive cycles.
- **Stall hold.** Hold `fifoe_rdy_i=0` for 5 cycles with `fifoe_vld_o=1` -> `fifoe_o` is unchanged every cycle and occupancies are unchanged apart from new pushes. After release, the next grant is port `last+1`.
- **Full and wrap.** Push 4 requests into port 3 with `fifoe_rdy_i=0` -> `occ_o[3]=4` and `req_rdy_o[3]=0`, and a 5th write is refused. Then drain and repeat for 3 rounds (12 requests) -> all 12 emerge in exact order with `port=3`.
- **Reset mid-operation.** Assert `rst` with 3 ports holding data and `fifoe_vld_o=1` -> `fifoe_vld_o=0` and all occupancies are 0 after reset. The first new request after reset is the first entry issued.

Source files
------------

// File: rtl/fta_bus_pkg.sv
// rtl/fta_bus_pkg.sv - FTA bus command request type carried by the mpmc11 request arbiter.
package fta_bus_pkg;

  typedef struct packed {
    logic [3:0]   cmd;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } fta_cmd_request256_t;

endpackage

// File: rtl/mpmc11_pkg.sv
// rtl/mpmc11_pkg.sv - mpmc11 controller FIFO entry: request tagged with its source port.
package mpmc11_pkg;

  typedef struct packed {
    logic [3:0]                       port;
    fta_bus_pkg::fta_cmd_request256_t req;
  } mpmc11_fifoe_t;

endpackage

// File: rtl/mpmc11_req_arb.sv
// rtl/mpmc11_req_arb.sv - per-port request FIFOs with a round-robin arbiter feeding one registered output.
// Output register reloads whenever it is empty or being consumed; otherwise everything holds.
module mpmc11_req_arb #(
  parameter int NPORT = 8,
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NPORT-1:0]                     req_vld_i,
  output logic [NPORT-1:0]                     req_rdy_o,
  input  fta_bus_pkg::fta_cmd_request256_t     req_i [NPORT],
  output mpmc11_pkg::mpmc11_fifoe_t            fifoe_o,
  output logic                                 fifoe_vld_o,
  input  logic                                 fifoe_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0]           occ_o [NPORT]
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int LW = (NPORT > 1) ? $clog2(NPORT) : 1;

  fta_bus_pkg::fta_cmd_request256_t r_mem [NPORT][DEPTH];
  logic [PW-1:0]              r_wptr [NPORT];
  logic [PW-1:0]              r_rptr [NPORT];
  logic [OW-1:0]              r_occ  [NPORT];
  logic [LW-1:0]              r_last;
  logic                       r_vld;
  mpmc11_pkg::mpmc11_fifoe_t  r_fifoe;

  logic [NPORT-1:0]                 w_push;
  logic [NPORT-1:0]                 w_pop;
  logic                             w_load;
  logic                             w_found;
  logic [LW-1:0]                    w_win;
  int                               w_idx;
  fta_bus_pkg::fta_cmd_request256_t w_head;

  assign w_load      = !r_vld || fifoe_rdy_i;
  assign fifoe_o     = r_fifoe;
  assign fifoe_vld_o = r_vld;

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      req_rdy_o[p] = !rst && (r_occ[p] != OW'(DEPTH));
      w_push[p]    = req_vld_i[p] && req_rdy_o[p];
      occ_o[p]     = r_occ[p];
    end
  end

  // Rotating search starting just after the last granted port.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 0; i < NPORT; i++) begin
      w_idx = (int'(r_last) + 1 + i) % NPORT;
      if (!w_found && (r_occ[w_idx] != '0)) begin
        w_found = 1'b1;
        w_win   = LW'(w_idx);
      end
    end
  end

  assign w_head = r_mem[w_win][r_rptr[w_win]];

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      w_pop[p] = w_load && w_found && (int'(w_win) == p);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (!rst && w_push[p]) begin
        r_mem[p][r_wptr[p]] <= req_i[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORT; p++) begin
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
        r_occ[p]  <= '0;
      end
      r_vld   <= 1'b0;
      r_fifoe <= '0;
      r_last  <= LW'(NPORT - 1);
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (w_push[p]) begin
          r_wptr[p] <= r_wptr[p] + PW'(1);
        end
        if (w_pop[p]) begin
          r_rptr[p] <= r_rptr[p] + PW'(1);
        end
        if (w_push[p] && !w_pop[p]) begin
          r_occ[p] <= r_occ[p] + OW'(1);
        end else if (!w_push[p] && w_pop[p]) begin
          r_occ[p] <= r_occ[p] - OW'(1);
        end
      end
      if (w_load) begin
        r_vld <= w_found;
        if (w_found) begin
          r_fifoe.port <= 4'(w_win);
          r_fifoe.req  <= w_head;
          r_last       <= w_win;
        end
      end
    end
  end

endmodule
